// File: rtl/pu_dot_sequencer.sv
// pu_dot_sequencer: buffers one VEC_LEN-element operand vector pair plus a bias,
// then streams two operand pairs per cycle into the combinational FP32
// processor_unit, feeding its output back as the running accumulator, and
// returns the final dot product over a valid/ready handshake.
// No FP arithmetic is done here; all values are raw IEEE-754 bit patterns.
// Optional build macro: PU_NAN_DETECT_EN adds a sticky res_nan output.
module pu_dot_sequencer #(
    parameter int VEC_LEN = 8,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_bias,
    output logic [DATA_W-1:0] pu_previous,
    output logic [DATA_W-1:0] pu_a0,
    output logic [DATA_W-1:0] pu_b0,
    output logic [DATA_W-1:0] pu_a1,
    output logic [DATA_W-1:0] pu_b1,
    input  logic [DATA_W-1:0] pu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data
`ifdef PU_NAN_DETECT_EN
    ,
    output logic              res_nan
`endif
);

    localparam int CW   = $clog2(VEC_LEN);
    localparam int HALF = VEC_LEN / 2;
    localparam int SW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] BEAT_LAST = CW'(VEC_LEN - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(HALF - 1);

    if ((VEC_LEN < 2) || ((VEC_LEN % 2) != 0)) begin : g_bad_vec_len
        $error("pu_dot_sequencer: VEC_LEN must be even and >= 2");
    end
    if (DATA_W != 32) begin : g_bad_data_w
        $error("pu_dot_sequencer: DATA_W must be 32 (FP32 only)");
    end

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              accept_s;
    logic [CW-1:0]     cnt_r;
    logic [SW-1:0]     step_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] res_data_r;
    logic              res_valid_r;
    logic              in_ready_r;
    logic [DATA_W-1:0] buf_a_r [VEC_LEN];
    logic [DATA_W-1:0] buf_b_r [VEC_LEN];
    logic [CW-1:0]     idx0_s;
    logic [CW-1:0]     idx1_s;

    assign in_ready  = in_ready_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; a beat is accepted only while loading.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            LOAD: begin
                accept_s = in_valid;
                if (in_valid && (cnt_r == BEAT_LAST)) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = LOAD;
                end
            end
            RUN: begin
                if (step_r == STEP_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = LOAD;
            end
        endcase
    end

    // Counters, accumulator and the registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= {CW{1'b0}};
            step_r      <= {SW{1'b0}};
            acc_r       <= {DATA_W{1'b0}};
            res_data_r  <= {DATA_W{1'b0}};
            res_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                LOAD: begin
                    step_r <= {SW{1'b0}};
                    if (accept_s) begin
                        if (cnt_r == BEAT_LAST) begin
                            cnt_r <= {CW{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                        if (cnt_r == {CW{1'b0}}) begin
                            acc_r <= in_bias;
                        end
                    end
                end
                RUN: begin
                    acc_r <= pu_out;
                    if (step_r == STEP_LAST) begin
                        step_r     <= {SW{1'b0}};
                        res_data_r <= pu_out;
                    end else begin
                        step_r <= step_r + SW'(1);
                    end
                end
                DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
            // in_ready/res_valid follow the state being entered, so in_ready
            // only rises the cycle after the result handshake.
            in_ready_r  <= (state_next_s == LOAD);
            res_valid_r <= (state_next_s == DONE);
        end
    end

    // Operand buffer; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (rst_n && accept_s) begin
            buf_a_r[cnt_r] <= in_a;
            buf_b_r[cnt_r] <= in_b;
        end
    end

    // Operand pair 2k/2k+1 and the accumulator go to processor_unit only in RUN.
    always_comb begin
        idx0_s      = CW'({step_r, 1'b0});
        idx1_s      = idx0_s + CW'(1);
        pu_previous = {DATA_W{1'b0}};
        pu_a0       = {DATA_W{1'b0}};
        pu_b0       = {DATA_W{1'b0}};
        pu_a1       = {DATA_W{1'b0}};
        pu_b1       = {DATA_W{1'b0}};
        if (state_r == RUN) begin
            pu_previous = acc_r;
            pu_a0       = buf_a_r[idx0_s];
            pu_b0       = buf_b_r[idx0_s];
            pu_a1       = buf_a_r[idx1_s];
            pu_b1       = buf_b_r[idx1_s];
        end else begin
            pu_previous = {DATA_W{1'b0}};
        end
    end

`ifdef PU_NAN_DETECT_EN
    logic nan_r;

    function automatic logic fp_is_nan(input logic [DATA_W-1:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    assign res_nan = nan_r;

    // Sticky NaN flag over all accepted operands; restarts on beat 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nan_r <= 1'b0;
        end else if (accept_s) begin
            if (cnt_r == {CW{1'b0}}) begin
                nan_r <= fp_is_nan(in_a) | fp_is_nan(in_b) | fp_is_nan(in_bias);
            end else begin
                nan_r <= nan_r | fp_is_nan(in_a) | fp_is_nan(in_b);
            end
        end else begin
            nan_r <= nan_r;
        end
    end
`endif

endmodule
